// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding and BCD constants for the serial BCD adder
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_fadd_1digit.sv
// bcd_fadd_1digit: one-digit BCD full adder with decimal carry
module bcd_fadd_1digit
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);
  logic [4:0] raw;
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout = raw > {1'b0, BCD_MAX};
    sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: adds two packed BCD operands one digit per cycle through a single digit adder
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] a_bcd,
  input  logic [4*NDIGITS-1:0] b_bcd,
  input  logic                 cin,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] sum_bcd,
  output logic                 cout,
  output logic                 err
);
  localparam int IDXW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [4*NDIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [3:0] da, db, dsum;
  logic dcarry;
  assign da = a_q[{idx_q, 2'b00} +: 4];
  assign db = b_q[{idx_q, 2'b00} +: 4];
  bcd_fadd_1digit u_fadd (
    .a   (da),
    .b   (db),
    .cin (carry_q),
    .cout(dcarry),
    .sum (dsum)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    if (state_q == IDLE && start) begin
      a_d     = a_bcd;
      b_d     = b_bcd;
      carry_d = cin;
      sum_d   = '0;
      cout_d  = 1'b0;
      err_d   = 1'b0;
      idx_d   = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      sum_d[{idx_q, 2'b00} +: 4] = dsum;
      carry_d = dcarry;
      err_d   = err_q | (da > BCD_MAX) | (db > BCD_MAX);
      if (idx_q == IDXW'(NDIGITS - 1)) begin
        cout_d  = dcarry;
        state_d = DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end
  assign ready   = state_q == IDLE;
  assign busy    = state_q == ADD;
  assign done    = state_q == DONE;
  assign sum_bcd = sum_q;
  assign cout    = cout_q;
  assign err     = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: vector table, scripted corner cases and random ops against a decimal-arithmetic model
module tb_bcd_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst_n = 1, start = 0, cin = 0;
  logic [W-1:0] a_bcd = '0, b_bcd = '0;
  logic ready, busy, done, cout, err;
  logic [W-1:0] sum_bcd;
  int total = 0, passed = 0;

  bcd_serial_adder #(.NDIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum_bcd(sum_bcd), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                output logic [W-1:0] s, output logic co, output logic e);
    longint x, y, p, t;
    x = 0; y = 0; p = 1; e = 0;
    for (int i = 0; i < N; i++) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) e = 1;
      x += longint'(a[4*i +: 4]) * p;
      y += longint'(b[4*i +: 4]) * p;
      p *= 10;
    end
    t = x + y + longint'(c);
    co = t >= p;
    t = t % p;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic eco, input logic ee);
    int lat;
    @(negedge clk);
    a_bcd = a; b_bcd = b; cin = c; start = 1;
    @(posedge clk); #1;
    start = 0;
    a_bcd = W'($urandom); b_bcd = W'($urandom); cin = 1'($urandom);
    chk({tag, "_busy"}, {ready, busy}, 2'b01);
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_err"}, err, ee);
    if (!ee) begin
      chk({tag, "_sum"}, sum_bcd, es);
      chk({tag, "_cout"}, cout, eco);
    end
    @(posedge clk); #1;
    chk({tag, "_idle"}, {ready, busy, done}, 3'b100);
    if (!ee) chk({tag, "_hold"}, sum_bcd, es);
  endtask

  initial begin
    vec_t vt[8];
    logic [W-1:0] qa[$], qb[$], ra, rb, es;
    logic qc[$];
    logic eco, ee, rc, nodone;
    int cyc, last, got;
    #5000000;
    $display("FAIL watchdog: simulation timeout, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [W-1:0] qa[$], qb[$], ra, rb, es;
    logic qc[$];
    logic eco, ee, rc, nodone;
    int cyc, last, got;
    vt[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vt[3] = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[6] = '{16'h5555, 16'h4444, 1'b0, 16'h9999, 1'b0, 1'b0};
    vt[7] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    #2 rst_n = 0;
    #1;
    chk("reset_ctl", {ready, busy, done}, 3'b100);
    chk("reset_res", {sum_bcd, cout, err}, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co, vt[i].e);

    for (int i = 0; i < 30; i++) begin
      ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ra[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      model(ra, rb, rc, es, eco, ee);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, es, eco, ee);
    end

    cyc = 0; last = -1; got = 0;
    @(negedge clk);
    a_bcd = 16'h0123; b_bcd = 16'h0456; cin = 0; start = 1;
    while (got < 3 && cyc < 60) begin
      if (busy) a_bcd = rand_bcd();
      if (ready && start) begin
        qa.push_back(a_bcd); qb.push_back(b_bcd); qc.push_back(cin);
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        model(qa.pop_front(), qb.pop_front(), qc.pop_front(), es, eco, ee);
        chk($sformatf("b2b%0d_sum", got), sum_bcd, es);
        chk($sformatf("b2b%0d_cout", got), cout, eco);
        if (last >= 0) chk($sformatf("b2b%0d_spacing", got), cyc - last, N + 2);
        last = cyc;
        got++;
      end
      @(negedge clk);
    end
    start = 0;
    chk("b2b_count", got, 3);

    @(negedge clk);
    a_bcd = 16'h1234; b_bcd = 16'h5678; cin = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("abort_partial", sum_bcd, 16'h0002);
    #2 rst_n = 0;
    #1;
    chk("abort_ctl", {ready, busy, done}, 3'b100);
    chk("abort_res", {sum_bcd, cout, err}, '0);
    nodone = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nodone = 0;
    end
    chk("abort_nodone", nodone, 1'b1);
    #2 rst_n = 1;
    do_op("post_reset", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
